// File: rtl/atm_session_arbiter.sv
// atm_session_arbiter: round-robin front end that shares one ATM core among
// N_TERM terminals. One session at a time: grant, hold the core inputs for
// CORE_CYCLES cycles, capture balance/success, then acknowledge the winner.
// Malformed requests (bad op or account) are answered immediately.
// Optional build macro ATM_ARB_LOCKOUT_EN adds per-account lockout after
// LOCK_THRESH consecutive failed sessions; without it no lock state exists.
module atm_session_arbiter #(
  parameter int N_TERM      = 2,
  parameter int CORE_CYCLES = 4,
  parameter int NUM_ACC     = 10,
  parameter int LOCK_THRESH = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_TERM-1:0]      req,
  input  logic [3*N_TERM-1:0]    req_op,
  input  logic [4*N_TERM-1:0]    req_acc,
  input  logic [16*N_TERM-1:0]   req_pin,
  input  logic [16*N_TERM-1:0]   req_newpin,
  input  logic [32*N_TERM-1:0]   req_amount,
  output logic [N_TERM-1:0]      ack,
  output logic                   rsp_valid,
  output logic [1:0]             rsp_status,
  output logic [31:0]            rsp_balance,
  output logic                   busy,
  output logic [2:0]             grant_id,
  output logic                   core_en,
  output logic [2:0]             core_op,
  output logic [3:0]             core_acc,
  output logic [15:0]            core_pin,
  output logic [15:0]            core_newpin,
  output logic [31:0]            core_amount,
  input  logic [31:0]            core_balance,
  input  logic                   core_success
);

  localparam int PTR_W = (N_TERM > 1) ? $clog2(N_TERM) : 1;
  localparam int RUN_W = (CORE_CYCLES > 1) ? $clog2(CORE_CYCLES) : 1;

  localparam logic [3:0]       MAX_ACC   = 4'(NUM_ACC);
  localparam logic [PTR_W-1:0] LAST_TERM = PTR_W'(N_TERM - 1);
  localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(CORE_CYCLES - 1);

  // Session states
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_RESPOND = 2'd3;

  // Response status codes
  localparam logic [1:0] RS_OK      = 2'd0;
  localparam logic [1:0] RS_FAIL    = 2'd1;
  localparam logic [1:0] RS_LOCKED  = 2'd2;
  localparam logic [1:0] RS_INVALID = 2'd3;

  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic [RUN_W-1:0] run_cnt_reg;
  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W-1:0] grant_reg;

  // Per-terminal request fields, unpacked from the flat buses
  logic [2:0]  op_arr     [N_TERM];
  logic [3:0]  acc_arr    [N_TERM];
  logic [15:0] pin_arr    [N_TERM];
  logic [15:0] newpin_arr [N_TERM];
  logic [31:0] amount_arr [N_TERM];

  for (genvar gi = 0; gi < N_TERM; gi++) begin : g_unpack
    assign op_arr[gi]     = req_op[3*gi +: 3];
    assign acc_arr[gi]    = req_acc[4*gi +: 4];
    assign pin_arr[gi]    = req_pin[16*gi +: 16];
    assign newpin_arr[gi] = req_newpin[16*gi +: 16];
    assign amount_arr[gi] = req_amount[32*gi +: 32];
  end

  // Round-robin search
  logic             win_found;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] cand;
  int               cand_int;

  // Pick the first asserted request scanning upward from the pointer
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    cand_int  = 0;
    for (int i = 0; i < N_TERM; i++) begin
      // (ptr + i) mod N_TERM without a divider: the sum never reaches 2*N_TERM
      cand_int = int'(ptr_reg) + i;
      if (cand_int >= N_TERM) cand_int = cand_int - N_TERM;
      cand = PTR_W'(cand_int);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Winner's fields and request classification
  logic [2:0]        sel_op;
  logic [3:0]        sel_acc;
  logic              op_ok;
  logic              acc_ok;
  logic              sel_locked;
  logic              sel_accept;
  logic [PTR_W-1:0]  ptr_next;
  logic [N_TERM-1:0] win_onehot;
  logic [N_TERM-1:0] grant_onehot;

  assign sel_op       = op_arr[win_idx];
  assign sel_acc      = acc_arr[win_idx];
  assign op_ok        = (sel_op >= 3'd3) && (sel_op <= 3'd6);
  assign acc_ok       = (sel_acc != 4'd0) && (sel_acc <= MAX_ACC);
  assign sel_accept   = op_ok && acc_ok && !sel_locked;
  assign ptr_next     = (win_idx == LAST_TERM) ? '0 : win_idx + 1'b1;
  assign win_onehot   = N_TERM'(1) << win_idx;
  assign grant_onehot = N_TERM'(1) << grant_reg;

`ifdef ATM_ARB_LOCKOUT_EN
  localparam int             LCW      = (LOCK_THRESH > 0) ? $clog2(LOCK_THRESH + 1) : 1;
  localparam logic [LCW-1:0] THRESH_V = LCW'(LOCK_THRESH);

  // Indexed directly by the 4-bit account number; entries above NUM_ACC stay idle
  logic [LCW-1:0] fail_cnt_reg [16];
  logic [15:0]    lock_reg;

  assign sel_locked = lock_reg[sel_acc];

  // Count consecutive failed sessions per account and latch the lock flag
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) fail_cnt_reg[i] <= '0;
      lock_reg <= '0;
    end else if (state_reg == ST_CAPTURE) begin
      if (core_success) begin
        fail_cnt_reg[core_acc] <= '0;
      end else if (fail_cnt_reg[core_acc] != THRESH_V) begin
        fail_cnt_reg[core_acc] <= fail_cnt_reg[core_acc] + 1'b1;
        if (fail_cnt_reg[core_acc] + 1'b1 == THRESH_V) lock_reg[core_acc] <= 1'b1;
      end
    end
  end
`else
  // Without lockout no account is ever locked; the threshold is simply not used
  logic unused_lock_cfg;
  assign unused_lock_cfg = (LOCK_THRESH != 0);
  assign sel_locked      = 1'b0;
`endif

  // Next-state selection for the session sequencer
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (win_found) state_next = sel_accept ? ST_RUN : ST_RESPOND;
      ST_RUN:     if (run_cnt_reg == RUN_LAST) state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = ST_RESPOND;
      ST_RESPOND: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // State register and busy flag (busy mirrors "not IDLE" without a decode delay)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      busy      <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy      <= (state_next != ST_IDLE);
    end
  end

  // Cycle counter for the core hold window
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt_reg <= '0;
    end else if (state_reg == ST_RUN && state_next == ST_RUN) begin
      run_cnt_reg <= run_cnt_reg + 1'b1;
    end else begin
      run_cnt_reg <= '0;
    end
  end

  // Round-robin pointer and grant bookkeeping; rejected grants also advance it
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg   <= '0;
      grant_reg <= '0;
      grant_id  <= 3'd0;
    end else if (state_reg == ST_IDLE && win_found) begin
      ptr_reg   <= ptr_next;
      grant_reg <= win_idx;
      grant_id  <= 3'(win_idx);
    end
  end

  // Core drive: latched at grant, held through RUN and CAPTURE, zeroed for RESPOND
  always_ff @(posedge clk) begin
    if (rst) begin
      core_en     <= 1'b0;
      core_op     <= 3'd0;
      core_acc    <= 4'd0;
      core_pin    <= 16'd0;
      core_newpin <= 16'd0;
      core_amount <= 32'd0;
    end else if (state_reg == ST_IDLE && win_found && sel_accept) begin
      core_en     <= 1'b1;
      core_op     <= sel_op;
      core_acc    <= sel_acc;
      core_pin    <= pin_arr[win_idx];
      core_newpin <= newpin_arr[win_idx];
      core_amount <= amount_arr[win_idx];
    end else if (state_reg == ST_CAPTURE) begin
      core_en     <= 1'b0;
      core_op     <= 3'd0;
      core_acc    <= 4'd0;
      core_pin    <= 16'd0;
      core_newpin <= 16'd0;
      core_amount <= 32'd0;
    end
  end

  // Response: one-cycle ack/valid strobe; status and balance hold until the next one
  always_ff @(posedge clk) begin
    if (rst) begin
      ack         <= '0;
      rsp_valid   <= 1'b0;
      rsp_status  <= RS_OK;
      rsp_balance <= 32'd0;
    end else begin
      ack       <= '0;
      rsp_valid <= 1'b0;
      if (state_reg == ST_IDLE && win_found && !sel_accept) begin
        ack         <= win_onehot;
        rsp_valid   <= 1'b1;
        rsp_status  <= (op_ok && acc_ok) ? RS_LOCKED : RS_INVALID;
        rsp_balance <= 32'd0;
      end else if (state_reg == ST_CAPTURE) begin
        ack         <= grant_onehot;
        rsp_valid   <= 1'b1;
        rsp_status  <= core_success ? RS_OK : RS_FAIL;
        rsp_balance <= core_balance;
      end
    end
  end

endmodule

// File: tb/tb_atm_session_arbiter.sv
// Bench for atm_session_arbiter: table-driven single-terminal sessions plus
// hand-written sequences for round-robin, lockout and mid-session reset.
// Expected responses go into a scoreboard queue when stimulus is driven and
// are compared by a monitor whenever rsp_valid is seen.
module tb_atm_session_arbiter;
  localparam int N_TERM      = 2;
  localparam int CORE_CYCLES = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   req = '0;
  logic [5:0]   req_op = '0;
  logic [7:0]   req_acc = '0;
  logic [31:0]  req_pin = '0;
  logic [31:0]  req_newpin = '0;
  logic [63:0]  req_amount = '0;
  logic [1:0]   ack;
  logic         rsp_valid;
  logic [1:0]   rsp_status;
  logic [31:0]  rsp_balance;
  logic         busy;
  logic [2:0]   grant_id;
  logic         core_en;
  logic [2:0]   core_op;
  logic [3:0]   core_acc;
  logic [15:0]  core_pin;
  logic [15:0]  core_newpin;
  logic [31:0]  core_amount;
  logic [31:0]  core_balance;
  logic         core_success;
  logic         core_fail = 1'b0;

  atm_session_arbiter #(.N_TERM(N_TERM), .CORE_CYCLES(CORE_CYCLES)) dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_acc(req_acc),
    .req_pin(req_pin), .req_newpin(req_newpin), .req_amount(req_amount),
    .ack(ack), .rsp_valid(rsp_valid), .rsp_status(rsp_status),
    .rsp_balance(rsp_balance), .busy(busy), .grant_id(grant_id),
    .core_en(core_en), .core_op(core_op), .core_acc(core_acc),
    .core_pin(core_pin), .core_newpin(core_newpin), .core_amount(core_amount),
    .core_balance(core_balance), .core_success(core_success)
  );

  // Simple core stand-in: balance = acc*1000 + amount, success unless told to fail
  assign core_balance = core_amount + 32'(core_acc) * 32'd1000;
  assign core_success = ~core_fail;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct {
    int          term;
    logic [2:0]  op;
    logic [3:0]  acc;
    logic [15:0] pin;
    logic [31:0] amt;
    bit          fail;
    logic [1:0]  st;
    logic [31:0] bal;
  } vec_t;

  typedef struct {
    int          term;
    logic [1:0]  st;
    logic [31:0] bal;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  function automatic vec_t mk(int term, logic [2:0] op, logic [3:0] acc, logic [15:0] pin,
                              logic [31:0] amt, bit fail, logic [1:0] st, logic [31:0] bal);
    vec_t v;
    v.term = term; v.op = op; v.acc = acc; v.pin = pin;
    v.amt = amt; v.fail = fail; v.st = st; v.bal = bal;
    return v;
  endfunction

  // Monitor: every response must match the oldest scoreboard entry
  always @(negedge clk) begin
    exp_t e;
    logic [1:0] oh;
    if (rsp_valid) begin
      $display("rsp cyc=%0d ack=%b grant=%0d status=%0d balance=%0d",
               cyc, ack, grant_id, rsp_status, rsp_balance);
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 64'(1), 64'(0));
      end else begin
        e  = sb.pop_front();
        oh = 2'b01 << e.term;
        chk("ack", 64'(ack), 64'(oh));
        chk("grant_id", 64'(grant_id), 64'(e.term));
        chk("status", 64'(rsp_status), 64'(e.st));
        chk("balance", 64'(rsp_balance), 64'(e.bal));
        chk("latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic set_term(input int k, input logic [2:0] op, input logic [3:0] acc,
                          input logic [15:0] pin, input logic [31:0] amt);
    req_op[3*k +: 3]      = op;
    req_acc[4*k +: 4]     = acc;
    req_pin[16*k +: 16]   = pin;
    req_newpin[16*k +: 16] = ~pin;
    req_amount[32*k +: 32] = amt;
  endtask

  // Reset for two cycles with both requests high; all outputs must be zero
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 2'b11;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ack", 64'(ack), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_core_en", 64'(core_en), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_core_op", 64'(core_op), 64'(0));
    chk("rst_core_acc", 64'(core_acc), 64'(0));
    chk("rst_core_pin", 64'(core_pin), 64'(0));
    chk("rst_core_newpin", 64'(core_newpin), 64'(0));
    chk("rst_core_amount", 64'(core_amount), 64'(0));
    chk("rst_grant_id", 64'(grant_id), 64'(0));
    chk("rst_status", 64'(rsp_status), 64'(0));
    chk("rst_balance", 64'(rsp_balance), 64'(0));
    rst = 1'b0;
    req = 2'b00;
  endtask

  // One session from a single terminal, checking the core window along the way
  task automatic run_txn(input vec_t v);
    bit   accepted;
    bit   en_ok;
    bit   got;
    exp_t e;
    accepted = (v.st == 2'd0) || (v.st == 2'd1);
    @(negedge clk);
    set_term(v.term, v.op, v.acc, v.pin, v.amt);
    core_fail = v.fail;
    req[v.term] = 1'b1;
    e.term = v.term; e.st = v.st; e.bal = v.bal;
    e.cyc  = cyc + (accepted ? CORE_CYCLES + 2 : 1);
    sb.push_back(e);
    en_ok = 1'b1;
    got   = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
      else if (accepted) begin
        if (!core_en || core_acc != v.acc || core_op != v.op || core_pin != v.pin ||
            core_newpin != ~v.pin || core_amount != v.amt || !busy) en_ok = 1'b0;
      end else if (core_en) en_ok = 1'b0;
    end
    chk("txn_resp_seen", 64'(got), 64'(1));
    chk("txn_core_window", 64'(en_ok), 64'(1));
    req[v.term] = 1'b0;
    @(negedge clk);
    chk("txn_busy_idle", 64'(busy), 64'(0));
    chk("txn_core_en_idle", 64'(core_en), 64'(0));
  endtask

  // Several requesters at once; acked terminals drop req and optionally re-raise
  task automatic run_multi(input logic [1:0] start, input int n_acks, input bit reraise);
    logic [1:0] pend;
    int         got;
    pend = '0;
    got  = 0;
    req  = start;
    for (int n = 0; n < 20 * n_acks && got < n_acks; n++) begin
      @(negedge clk);
      req  = req | pend;
      pend = '0;
      if (rsp_valid) begin
        got++;
        if (got == n_acks) req = '0;
        else begin
          req = req & ~ack;
          if (reraise) pend = ack;
        end
      end
    end
    chk("multi_acks", 64'(got), 64'(n_acks));
    req = '0;
    @(negedge clk);
    chk("multi_busy_idle", 64'(busy), 64'(0));
  endtask

  vec_t vt[9];

  initial begin
    exp_t e;
    bit   seen;
    int   c0;

    vt[0] = mk(0, 3'd3, 4'd1,  16'd1234, 32'd4000, 1'b0, 2'd0, 32'd5000);
    vt[1] = mk(1, 3'd3, 4'd0,  16'd1111, 32'd10,   1'b0, 2'd3, 32'd0);
    vt[2] = mk(1, 3'd3, 4'd11, 16'd1111, 32'd10,   1'b0, 2'd3, 32'd0);
    vt[3] = mk(1, 3'd7, 4'd2,  16'd1111, 32'd10,   1'b0, 2'd3, 32'd0);
    vt[4] = mk(0, 3'd4, 4'd5,  16'd4321, 32'd250,  1'b0, 2'd0, 32'd5250);
    vt[5] = mk(1, 3'd5, 4'd10, 16'd9999, 32'd7,    1'b1, 2'd1, 32'd10007);
    vt[6] = mk(0, 3'd6, 4'd3,  16'd2222, 32'd0,    1'b0, 2'd0, 32'd3000);
    vt[7] = mk(1, 3'd2, 4'd3,  16'd2222, 32'd5,    1'b0, 2'd3, 32'd0);
    vt[8] = mk(0, 3'd3, 4'd15, 16'd2222, 32'd5,    1'b0, 2'd3, 32'd0);

    do_reset();

    for (int i = 0; i < 9; i++) run_txn(vt[i]);

    // Round robin from a fresh pointer: grants 0,1,0,1, 7 cycles per session
    do_reset();
    set_term(0, 3'd3, 4'd1, 16'd1000, 32'd100);
    set_term(1, 3'd4, 4'd4, 16'd2000, 32'd200);
    core_fail = 1'b0;
    @(negedge clk);
    c0 = cyc;
    for (int k = 0; k < 4; k++) begin
      e.term = k % 2;
      e.st   = 2'd0;
      e.bal  = (k % 2 == 0) ? 32'd1100 : 32'd4200;
      e.cyc  = c0 + CORE_CYCLES + 2 + 7 * k;
      sb.push_back(e);
    end
    run_multi(2'b11, 4, 1'b1);

    // Repeated failures on account 2
    for (int k = 0; k < 3; k++) run_txn(mk(1, 3'd3, 4'd2, 16'd55, 32'd50, 1'b1, 2'd1, 32'd2050));
`ifdef ATM_ARB_LOCKOUT_EN
    run_txn(mk(1, 3'd3, 4'd2, 16'd55, 32'd50, 1'b1, 2'd2, 32'd0));
`else
    run_txn(mk(1, 3'd3, 4'd2, 16'd55, 32'd50, 1'b1, 2'd1, 32'd2050));
`endif
    run_txn(mk(1, 3'd4, 4'd3, 16'd56, 32'd1, 1'b0, 2'd0, 32'd3001));
    do_reset();
    run_txn(mk(0, 3'd3, 4'd2, 16'd55, 32'd9, 1'b0, 2'd0, 32'd2009));

    // Reset in the middle of RUN: session dropped, no ack
    set_term(0, 3'd3, 4'd1, 16'd77, 32'd1);
    core_fail = 1'b0;
    @(negedge clk);
    req = 2'b01;
    @(negedge clk);
    chk("midrun_core_en_on", 64'(core_en), 64'(1));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req = 2'b00;
    chk("midrun_core_en_off", 64'(core_en), 64'(0));
    chk("midrun_busy_off", 64'(busy), 64'(0));
    chk("midrun_ack_off", 64'(ack), 64'(0));
    seen = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("midrun_no_ack", 64'(seen), 64'(0));

    // Pointer restarts at 0 after reset: T0 beats T1, then T1 is served
    set_term(0, 3'd3, 4'd5, 16'd11, 32'd1);
    set_term(1, 3'd3, 4'd6, 16'd22, 32'd2);
    @(negedge clk);
    c0 = cyc;
    e.term = 0; e.st = 2'd0; e.bal = 32'd5001; e.cyc = c0 + CORE_CYCLES + 2;
    sb.push_back(e);
    e.term = 1; e.st = 2'd0; e.bal = 32'd6002; e.cyc = c0 + CORE_CYCLES + 2 + 7;
    sb.push_back(e);
    run_multi(2'b11, 2, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
